fibonacci_scheduler: RTL and testbench

Shares one iterative Fibonacci engine between NREQ requesters. Each requester presents an index n. The block grants one requester at a time (round-robin), computes F(n) over n+1 cycles, and returns the result tagged with the requester id. It sits between the client logic and the Fibonacci datapath, replacing direct per-client fibonacci_top instances.

---
 rtl/fibonacci_pkg.sv | 26 ++
 rtl/fibonacci_rr_arbiter.sv | 39 +++
 rtl/fibonacci_scheduler.sv | 141 ++++++++++++++
 tb/tb_fibonacci_scheduler.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fibonacci_pkg.sv
// ============================================================================
// Module : fibonacci_pkg
// Brief  : Shared types and constants for the Fibonacci scheduler slice.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fibonacci_pkg;

  localparam int FIB_WIDTH = 8;
  localparam int FIB_NREQ  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESPOND = 2'd2
  } state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int fib_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fibonacci_rr_arbiter.sv
// ============================================================================
// Module : fibonacci_rr_arbiter
// Brief  : Combinational round-robin pick, searching upward from last+1.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fibonacci_rr_arbiter
  import fibonacci_pkg::*;
#(
  parameter int NREQ = FIB_NREQ,
  parameter int IDW  = fib_id_w(FIB_NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int pos;
      pos = (int'(last_i) + k) % NREQ;
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = IDW'(pos);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fibonacci_scheduler.sv
// ============================================================================
// Module : fibonacci_scheduler
// Brief  : Round-robin sharing of one iterative Fibonacci engine.
//          Optional macro FIB_SATURATE_EN clamps overflowed results to all-ones.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fibonacci_scheduler
  import fibonacci_pkg::*;
#(
  parameter  int WIDTH = FIB_WIDTH,
  parameter  int NREQ  = FIB_NREQ,
  localparam int IDW   = fib_id_w(NREQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_n,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      fibonacci,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic                  overflow,
  output logic                  busy
);

  state_t           state_q, state_d;
  logic [IDW-1:0]   last_q, last_d, id_q, id_d, rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, cnt_q, cnt_d, fib_q, fib_d;
  logic             ova_q, ova_d, ovb_q, ovb_d, ovf_q, ovf_d;

  logic [NREQ-1:0]  arb_gnt;
  logic [IDW-1:0]   arb_idx;
  logic [WIDTH-1:0] n_sel;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] result;

  fibonacci_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx)
  );

  assign n_sel = req_n[int'(arb_idx)*WIDTH +: WIDTH];
  assign sum   = {1'b0, a_q} + {1'b0, b_q};

`ifdef FIB_SATURATE_EN
  assign result = ova_q ? {WIDTH{1'b1}} : a_q;
`else
  assign result = a_q;
`endif

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    id_d     = id_q;
    rsp_id_d = rsp_id_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    fib_d    = fib_q;
    ova_d    = ova_q;
    ovb_d    = ovb_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          id_d    = arb_idx;
          last_d  = arb_idx;
          a_d     = '0;
          b_d     = WIDTH'(1);
          cnt_d   = n_sel;
          ova_d   = 1'b0;
          ovb_d   = 1'b0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        if (cnt_q == '0) begin
          fib_d    = result;
          ovf_d    = ova_q;
          rsp_id_d = id_q;
          state_d  = RESPOND;
        end else begin
          // ova follows a; only the wrap history of the returned value matters.
          a_d   = b_q;
          ova_d = ovb_q;
          b_d   = sum[WIDTH-1:0];
          ovb_d = ova_q | ovb_q | sum[WIDTH];
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= IDW'(NREQ - 1);
      id_q     <= '0;
      rsp_id_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      fib_q    <= '0;
      ova_q    <= 1'b0;
      ovb_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      rsp_id_q <= rsp_id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      fib_q    <= fib_d;
      ova_q    <= ova_d;
      ovb_q    <= ovb_d;
      ovf_q    <= ovf_d;
    end
  end

  // Grant is masked during reset so nothing is offered while the engine is held.
  assign gnt       = (state_q == IDLE && !reset) ? arb_gnt : '0;
  assign rsp_valid = (state_q == RESPOND);
  assign busy      = (state_q != IDLE);
  assign fibonacci = fib_q;
  assign rsp_id    = rsp_id_q;
  assign overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_fibonacci_scheduler.sv
// ============================================================================
// Module : tb_fibonacci_scheduler
// Brief  : Directed, table-driven self-checking bench for fibonacci_scheduler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fibonacci_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_n;
  logic [3:0]  gnt;
  logic [7:0]  fibonacci;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic        overflow;
  logic        busy;

  int errors = 0;
  int checks = 0;

  fibonacci_scheduler #(.WIDTH(8), .NREQ(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .req_n     (req_n),
    .gnt       (gnt),
    .fibonacci (fibonacci),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         rid;
    logic [7:0] n;
    logic [7:0] fib;
    logic       ovf;
  } vec_t;

  vec_t vecs[6];

`ifdef FIB_SATURATE_EN
  localparam logic [7:0] FIB14 = 8'd255;
`else
  localparam logic [7:0] FIB14 = 8'd121;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_gnt(input string nm);
    int t;
    t = 0;
    while (gnt == 4'b0 && t < 100) begin
      step();
      t++;
    end
    if (t >= 100) chk({nm, "_gnt_timeout"}, 32'(t), 32'd0);
  endtask

  // Waits for rsp_valid; returns cycles elapsed counting the caller's first step as 1.
  task automatic wait_rsp(input string nm, output int lat);
    lat = 1;
    while (!rsp_valid && lat < 300) begin
      chk({nm, "_busy"}, 32'(busy), 32'd1);
      chk({nm, "_gnt_quiet"}, 32'(gnt), 32'd0);
      step();
      lat++;
    end
    if (lat >= 300) chk({nm, "_rsp_timeout"}, 32'(lat), 32'd0);
  endtask

  task automatic do_job(input vec_t v, input string nm);
    int lat;
    req_n[v.rid*8 +: 8] = v.n;
    req[v.rid] = 1'b1;
    #1;
    wait_gnt(nm);
    chk({nm, "_gnt"}, 32'(gnt), 32'(4'b1 << v.rid));
    step();
    req[v.rid] = 1'b0;
    wait_rsp(nm, lat);
    chk({nm, "_latency"}, 32'(lat), 32'(v.n) + 32'd2);
    chk({nm, "_fib"}, 32'(fibonacci), 32'(v.fib));
    chk({nm, "_id"}, 32'(rsp_id), 32'(v.rid));
    chk({nm, "_ovf"}, 32'(overflow), 32'(v.ovf));
    step();
    chk({nm, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int order[5];
    logic [7:0] rr_fib[5];
    int lat;
    int seen;

    vecs[0] = '{rid: 0, n: 8'd10, fib: 8'd55,  ovf: 1'b0};
    vecs[1] = '{rid: 2, n: 8'd0,  fib: 8'd0,   ovf: 1'b0};
    vecs[2] = '{rid: 2, n: 8'd1,  fib: 8'd1,   ovf: 1'b0};
    vecs[3] = '{rid: 1, n: 8'd14, fib: FIB14,  ovf: 1'b1};
    vecs[4] = '{rid: 3, n: 8'd13, fib: 8'd233, ovf: 1'b0};
    vecs[5] = '{rid: 0, n: 8'd12, fib: 8'd144, ovf: 1'b0};
    order  = '{0, 1, 2, 3, 0};
    rr_fib = '{8'd2, 8'd5, 8'd13, 8'd233, 8'd2};

    reset = 1'b1;
    req   = 4'b1111;
    req_n = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_fib", 32'(fibonacci), 32'd0);
    end
    req   = 4'b0;
    reset = 1'b0;
    step();

    for (int i = 0; i < 6; i++) do_job(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of an n=10 job: outputs clear at once and no response follows.
    req_n[15:8] = 8'd10;
    req[1] = 1'b1;
    #1;
    wait_gnt("midrst");
    chk("midrst_gnt", 32'(gnt), 32'd2);
    step();
    req[1] = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("midrst_busy_before", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_fib", 32'(fibonacci), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (rsp_valid) seen++;
    end
    chk("midrst_no_rsp", 32'(seen), 32'd0);

    // All four request at once; requester 0 re-arms during job 1 and must wait for 3.
    req_n = {8'd13, 8'd7, 8'd5, 8'd3};
    req   = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      wait_gnt($sformatf("rr%0d", k));
      chk($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(4'b1 << order[k]));
      step();
      req[order[k]] = 1'b0;
      if (k == 1) req[0] = 1'b1;
      wait_rsp($sformatf("rr%0d", k), lat);
      chk($sformatf("rr%0d_fib", k), 32'(fibonacci), 32'(rr_fib[k]));
      chk($sformatf("rr%0d_id", k), 32'(rsp_id), 32'(order[k]));
      chk($sformatf("rr%0d_ovf", k), 32'(overflow), 32'd0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
